psg_stereo_dac: RTL and testbench

PSG_STEREO_DAC -- requirements
Module: psg_stereo_dac

---
 rtl/psg_audio_pkg.sv | 22 ++
 rtl/sd_dac1.sv | 25 ++
 rtl/psg_stereo_dac.sv | 186 ++++++++++++++++++
 tb/tb_psg_stereo_dac.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psg_audio_pkg.sv
// rtl/psg_audio_pkg.sv - shared types and constants for the PSG stereo DAC
package psg_audio_pkg;

  typedef enum logic [1:0] {
    ST_ABC  = 2'b00,
    ST_ACB  = 2'b01,
    ST_MONO = 2'b10
  } stereo_e;

  typedef enum logic [1:0] {
    G_PLAY     = 2'd0,
    G_FADE_OUT = 2'd1,
    G_MUTED    = 2'd2,
    G_FADE_IN  = 2'd3
  } gain_state_e;

  localparam int GAIN_MAX   = 16;
  localparam int PCM_W      = 10;
  localparam int BEEPER_LVL = 128;
  localparam int TAPE_LVL   = 32;

endpackage

// File: rtl/sd_dac1.sv
// rtl/sd_dac1.sv - first-order sigma-delta modulator, carry-out is the bitstream
module sd_dac1 (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [9:0] DIN,
  output logic       DOUT
);

  logic [10:0] acc_q, acc_d;

  always_comb begin
    acc_d = {1'b0, acc_q[9:0]} + {1'b0, DIN};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign DOUT = acc_q[10];

endmodule

// File: rtl/psg_stereo_dac.sv
// rtl/psg_stereo_dac.sv - PSG/beeper/tape stereo mixer with fade gain and sigma-delta outputs
module psg_stereo_dac
  import psg_audio_pkg::*;
#(
  parameter int FADE_STEP = 64
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CE,
  input  logic [7:0] CH_A,
  input  logic [7:0] CH_B,
  input  logic [7:0] CH_C,
  input  logic       BEEPER,
  input  logic       TAPE_IN,
  input  logic [1:0] STEREO,
  input  logic       MUTE,
  output logic [9:0] PCM_L,
  output logic [9:0] PCM_R,
  output logic       PCM_VALID,
  output logic       AUDIO_L,
  output logic       AUDIO_R
);

  localparam int               CNT_W     = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FADE_STEP - 1);
  localparam logic [4:0]       GAIN_FULL = 5'(GAIN_MAX);

  logic [7:0]       a_q, a_d, b_q, b_d, c_q, c_d;
  logic             beep_q, beep_d, tape_q, tape_d;
  logic [1:0]       stereo_q, stereo_d;
  logic             s1_vld_q, s1_vld_d;
  logic [PCM_W-1:0] raw_l_q, raw_l_d, raw_r_q, raw_r_d;
  logic             s2_vld_q, s2_vld_d;
  logic [PCM_W-1:0] pcm_l_q, pcm_l_d, pcm_r_q, pcm_r_d;
  logic             pcm_vld_q, pcm_vld_d;
  gain_state_e      state_q, state_d;
  logic [4:0]       gain_q, gain_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PCM_W-1:0] a10, b10, c10, ext;
  logic [14:0]      prod_l, prod_r;

  always_comb begin
    a_d      = CE ? CH_A : a_q;
    b_d      = CE ? CH_B : b_q;
    c_d      = CE ? CH_C : c_q;
    beep_d   = CE ? BEEPER : beep_q;
    tape_d   = CE ? TAPE_IN : tape_q;
    stereo_d = CE ? STEREO : stereo_q;
    s1_vld_d = CE;
  end

  always_comb begin
    a10      = {2'b00, a_q};
    b10      = {2'b00, b_q};
    c10      = {2'b00, c_q};
    ext      = (beep_q ? PCM_W'(BEEPER_LVL) : '0) + (tape_q ? PCM_W'(TAPE_LVL) : '0);
    raw_l_d  = raw_l_q;
    raw_r_d  = raw_r_q;
    s2_vld_d = s1_vld_q;
    if (s1_vld_q) begin
      case (stereo_q)
        ST_ABC: begin
          raw_l_d = (a10 << 1) + b10 + ext;
          raw_r_d = (c10 << 1) + b10 + ext;
        end
        ST_ACB: begin
          raw_l_d = (a10 << 1) + c10 + ext;
          raw_r_d = (b10 << 1) + c10 + ext;
        end
        default: begin
          raw_l_d = a10 + b10 + c10 + ext;
          raw_r_d = a10 + b10 + c10 + ext;
        end
      endcase
    end
  end

  // Full-width product so gain 16 reproduces raw exactly after the shift.
  always_comb begin
    prod_l    = 15'(raw_l_q) * 15'(gain_q);
    prod_r    = 15'(raw_r_q) * 15'(gain_q);
    pcm_l_d   = s2_vld_q ? PCM_W'(prod_l >> 4) : pcm_l_q;
    pcm_r_d   = s2_vld_q ? PCM_W'(prod_r >> 4) : pcm_r_q;
    pcm_vld_d = s2_vld_q;
  end

  // Gain steps on the sample being scaled now, so it takes effect on the next one.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    cnt_d   = cnt_q;
    case (state_q)
      G_PLAY: begin
        gain_d = GAIN_FULL;
        if (MUTE) begin
          state_d = G_FADE_OUT;
          cnt_d   = '0;
        end
      end
      G_FADE_OUT: begin
        if (!MUTE) begin
          state_d = G_FADE_IN;
          cnt_d   = '0;
        end else if (gain_q == 5'd0) begin
          state_d = G_MUTED;
          cnt_d   = '0;
        end else if (s2_vld_q) begin
          if (cnt_q == CNT_LAST) begin
            gain_d = gain_q - 5'd1;
            cnt_d  = '0;
            if (gain_q == 5'd1) state_d = G_MUTED;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      G_MUTED: begin
        gain_d = 5'd0;
        if (!MUTE) begin
          state_d = G_FADE_IN;
          cnt_d   = '0;
        end
      end
      default: begin
        if (MUTE) begin
          state_d = G_FADE_OUT;
          cnt_d   = '0;
        end else if (s2_vld_q) begin
          if (cnt_q == CNT_LAST) begin
            gain_d = gain_q + 5'd1;
            cnt_d  = '0;
            if (gain_q == GAIN_FULL - 5'd1) state_d = G_PLAY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      beep_q    <= 1'b0;
      tape_q    <= 1'b0;
      stereo_q  <= '0;
      s1_vld_q  <= 1'b0;
      raw_l_q   <= '0;
      raw_r_q   <= '0;
      s2_vld_q  <= 1'b0;
      pcm_l_q   <= '0;
      pcm_r_q   <= '0;
      pcm_vld_q <= 1'b0;
      state_q   <= G_PLAY;
      gain_q    <= GAIN_FULL;
      cnt_q     <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      beep_q    <= beep_d;
      tape_q    <= tape_d;
      stereo_q  <= stereo_d;
      s1_vld_q  <= s1_vld_d;
      raw_l_q   <= raw_l_d;
      raw_r_q   <= raw_r_d;
      s2_vld_q  <= s2_vld_d;
      pcm_l_q   <= pcm_l_d;
      pcm_r_q   <= pcm_r_d;
      pcm_vld_q <= pcm_vld_d;
      state_q   <= state_d;
      gain_q    <= gain_d;
      cnt_q     <= cnt_d;
    end
  end

  assign PCM_L     = pcm_l_q;
  assign PCM_R     = pcm_r_q;
  assign PCM_VALID = pcm_vld_q;

  sd_dac1 u_sd_l (.CLK(CLK), .RESET(RESET), .DIN(pcm_l_q), .DOUT(AUDIO_L));
  sd_dac1 u_sd_r (.CLK(CLK), .RESET(RESET), .DIN(pcm_r_q), .DOUT(AUDIO_R));

endmodule

// File: tb/tb_psg_stereo_dac.sv
// tb/tb_psg_stereo_dac.sv - directed self-checking bench for psg_stereo_dac
module tb_psg_stereo_dac;

  logic       CLK = 1'b0;
  logic       RESET, CE, BEEPER, TAPE_IN, MUTE;
  logic [7:0] CH_A, CH_B, CH_C;
  logic [1:0] STEREO;
  logic [9:0] PCM_L, PCM_R;
  logic       PCM_VALID, AUDIO_L, AUDIO_R;
  int         n_cmp = 0;
  int         n_bad = 0;

  psg_stereo_dac #(.FADE_STEP(4)) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE),
    .CH_A(CH_A), .CH_B(CH_B), .CH_C(CH_C),
    .BEEPER(BEEPER), .TAPE_IN(TAPE_IN), .STEREO(STEREO), .MUTE(MUTE),
    .PCM_L(PCM_L), .PCM_R(PCM_R), .PCM_VALID(PCM_VALID),
    .AUDIO_L(AUDIO_L), .AUDIO_R(AUDIO_R)
  );

  always #5 CLK = ~CLK;

  task automatic set_in(input int a, input int b, input int c, input logic beep, input logic tape,
                        input logic [1:0] st);
    CH_A = 8'(a); CH_B = 8'(b); CH_C = 8'(c);
    BEEPER = beep; TAPE_IN = tape; STEREO = st;
  endtask

  task automatic test_reset();
    RESET = 1'b1; CE = 1'b1; MUTE = 1'b0;
    set_in(200, 100, 50, 1'b1, 1'b1, 2'b00);
    repeat (2) @(negedge CLK);
    RESET = 1'b0; CE = 1'b0;
    n_cmp += 5;
    if (PCM_L !== 10'd0) begin n_bad++; $display("FAIL reset_pcm_l got %0d want 0", PCM_L); end
    if (PCM_R !== 10'd0) begin n_bad++; $display("FAIL reset_pcm_r got %0d want 0", PCM_R); end
    if (PCM_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", PCM_VALID); end
    if (AUDIO_L !== 1'b0) begin n_bad++; $display("FAIL reset_audio_l got %b want 0", AUDIO_L); end
    if (AUDIO_R !== 1'b0) begin n_bad++; $display("FAIL reset_audio_r got %b want 0", AUDIO_R); end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (PCM_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_ce_discard cyc=%0d got %b want 0", i, PCM_VALID); end
    end
  endtask

  task automatic test_abc();
    set_in(100, 50, 10, 1'b1, 1'b0, 2'b00);
    CE = 1'b1;
    @(negedge CLK); CE = 1'b0;
    n_cmp++;
    if (PCM_VALID !== 1'b0) begin n_bad++; $display("FAIL abc_lat1 got %b want 0", PCM_VALID); end
    @(negedge CLK);
    n_cmp++;
    if (PCM_VALID !== 1'b0) begin n_bad++; $display("FAIL abc_lat2 got %b want 0", PCM_VALID); end
    @(negedge CLK);
    n_cmp += 3;
    if (PCM_VALID !== 1'b1) begin n_bad++; $display("FAIL abc_valid got %b want 1", PCM_VALID); end
    if (PCM_L !== 10'd378) begin n_bad++; $display("FAIL abc_l got %0d want 378", PCM_L); end
    if (PCM_R !== 10'd198) begin n_bad++; $display("FAIL abc_r got %0d want 198", PCM_R); end
    @(negedge CLK);
    n_cmp += 2;
    if (PCM_VALID !== 1'b0) begin n_bad++; $display("FAIL abc_pulse got %b want 0", PCM_VALID); end
    if (PCM_L !== 10'd378) begin n_bad++; $display("FAIL abc_hold got %0d want 378", PCM_L); end
  endtask

  task automatic test_mix();
    int         va[5] = '{255, 0, 10, 255, 0};
    int         vb[5] = '{255, 200, 20, 255, 0};
    int         vc[5] = '{255, 1, 30, 255, 0};
    logic       vbp[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       vtp[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0] vst[5] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b00};
    int         el[5] = '{797, 1, 220, 925, 0};
    int         er[5] = '{797, 401, 220, 925, 0};
    for (int i = 0; i < 5; i++) begin
      set_in(va[i], vb[i], vc[i], vbp[i], vtp[i], vst[i]);
      CE = 1'b1;
      @(negedge CLK); CE = 1'b0;
      repeat (2) @(negedge CLK);
      n_cmp += 3;
      if (PCM_VALID !== 1'b1) begin n_bad++; $display("FAIL mix%0d_valid got %b want 1", i, PCM_VALID); end
      if (PCM_L !== 10'(el[i])) begin n_bad++; $display("FAIL mix%0d_l got %0d want %0d", i, PCM_L, el[i]); end
      if (PCM_R !== 10'(er[i])) begin n_bad++; $display("FAIL mix%0d_r got %0d want %0d", i, PCM_R, er[i]); end
      @(negedge CLK);
    end
  endtask

  task automatic test_back_to_back();
    int         ba[3] = '{1, 4, 7};
    int         bb[3] = '{2, 5, 8};
    int         bc[3] = '{3, 6, 9};
    logic       bt[3] = '{1'b0, 1'b0, 1'b1};
    logic [1:0] bs[3] = '{2'b00, 2'b01, 2'b10};
    int         el[3] = '{4, 14, 56};
    int         er[3] = '{8, 16, 56};
    logic       want_v;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin
        set_in(ba[i], bb[i], bc[i], 1'b0, bt[i], bs[i]);
        CE = 1'b1;
      end else begin
        CE = 1'b0;
      end
      @(negedge CLK);
      want_v = (i >= 2 && i <= 4);
      n_cmp++;
      if (PCM_VALID !== want_v) begin n_bad++; $display("FAIL b2b_valid cyc=%0d got %b want %b", i, PCM_VALID, want_v); end
      if (want_v) begin
        n_cmp += 2;
        if (PCM_L !== 10'(el[i-2])) begin n_bad++; $display("FAIL b2b_l s=%0d got %0d want %0d", i-2, PCM_L, el[i-2]); end
        if (PCM_R !== 10'(er[i-2])) begin n_bad++; $display("FAIL b2b_r s=%0d got %0d want %0d", i-2, PCM_R, er[i-2]); end
      end
    end
  endtask

  task automatic test_fade_release();
    int k = 0;
    int e_pcm;
    set_in(255, 162, 255, 1'b1, 1'b0, 2'b00);
    MUTE = 1'b1;
    @(negedge CLK);
    for (int n = 0; n < 35; n++) begin
      CE = (n < 32);
      @(negedge CLK);
      if (PCM_VALID) begin
        e_pcm = 50 * (16 - k / 4);
        n_cmp++;
        if (PCM_L !== 10'(e_pcm) || PCM_R !== 10'(e_pcm)) begin
          n_bad++; $display("FAIL fade_down k=%0d got %0d/%0d want %0d", k, PCM_L, PCM_R, e_pcm);
        end
        k++;
      end
    end
    CE = 1'b0;
    n_cmp++;
    if (k !== 32) begin n_bad++; $display("FAIL fade_down_count got %0d want 32", k); end
    MUTE = 1'b0;
    @(negedge CLK);
    k = 0;
    for (int n = 0; n < 43; n++) begin
      CE = (n < 40);
      @(negedge CLK);
      if (PCM_VALID) begin
        e_pcm = (k / 4 >= 8) ? 800 : 50 * (8 + k / 4);
        n_cmp++;
        if (PCM_L !== 10'(e_pcm) || PCM_R !== 10'(e_pcm)) begin
          n_bad++; $display("FAIL fade_up k=%0d got %0d/%0d want %0d", k, PCM_L, PCM_R, e_pcm);
        end
        k++;
      end
    end
    CE = 1'b0;
    n_cmp++;
    if (k !== 40) begin n_bad++; $display("FAIL fade_up_count got %0d want 40", k); end
  endtask

  task automatic test_reset_mid_fade();
    set_in(255, 162, 255, 1'b1, 1'b0, 2'b00);
    MUTE = 1'b1;
    CE = 1'b1;
    repeat (12) @(negedge CLK);
    RESET = 1'b1; MUTE = 1'b0;
    @(negedge CLK);
    n_cmp += 5;
    if (PCM_L !== 10'd0) begin n_bad++; $display("FAIL midrst_l got %0d want 0", PCM_L); end
    if (PCM_R !== 10'd0) begin n_bad++; $display("FAIL midrst_r got %0d want 0", PCM_R); end
    if (PCM_VALID !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got %b want 0", PCM_VALID); end
    if (AUDIO_L !== 1'b0) begin n_bad++; $display("FAIL midrst_audio_l got %b want 0", AUDIO_L); end
    if (AUDIO_R !== 1'b0) begin n_bad++; $display("FAIL midrst_audio_r got %b want 0", AUDIO_R); end
    RESET = 1'b0; CE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (PCM_VALID !== 1'b0) begin n_bad++; $display("FAIL midrst_discard cyc=%0d got %b want 0", i, PCM_VALID); end
    end
    CE = 1'b1;
    @(negedge CLK); CE = 1'b0;
    repeat (2) @(negedge CLK);
    n_cmp += 2;
    if (PCM_VALID !== 1'b1) begin n_bad++; $display("FAIL midrst_next_valid got %b want 1", PCM_VALID); end
    if (PCM_L !== 10'd800) begin n_bad++; $display("FAIL midrst_gain got %0d want 800", PCM_L); end
    @(negedge CLK);
  endtask

  task automatic test_fade_full();
    int k = 0;
    int e_pcm;
    MUTE = 1'b1;
    @(negedge CLK);
    for (int n = 0; n < 73; n++) begin
      CE = (n < 70);
      @(negedge CLK);
      if (PCM_VALID) begin
        e_pcm = (k >= 64) ? 0 : 50 * (16 - k / 4);
        n_cmp++;
        if (PCM_L !== 10'(e_pcm)) begin n_bad++; $display("FAIL fade_full k=%0d got %0d want %0d", k, PCM_L, e_pcm); end
        k++;
      end
    end
    CE = 1'b0;
    n_cmp++;
    if (k !== 70) begin n_bad++; $display("FAIL fade_full_count got %0d want 70", k); end
  endtask

  task automatic test_sigma_delta();
    int ones_l = 0;
    int ones_r = 0;
    RESET = 1'b1; MUTE = 1'b0; CE = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    set_in(128, 0, 128, 1'b0, 1'b0, 2'b00);
    CE = 1'b1;
    @(negedge CLK); CE = 1'b0;
    repeat (12) @(negedge CLK);
    n_cmp++;
    if (PCM_L !== 10'd256) begin n_bad++; $display("FAIL sd_pcm256 got %0d want 256", PCM_L); end
    for (int i = 0; i < 1024; i++) begin
      @(negedge CLK);
      ones_l += int'(AUDIO_L);
      ones_r += int'(AUDIO_R);
    end
    n_cmp += 2;
    if (ones_l !== 256) begin n_bad++; $display("FAIL sd_density_l got %0d want 256", ones_l); end
    if (ones_r !== 256) begin n_bad++; $display("FAIL sd_density_r got %0d want 256", ones_r); end
    set_in(0, 0, 0, 1'b0, 1'b0, 2'b00);
    CE = 1'b1;
    @(negedge CLK); CE = 1'b0;
    repeat (12) @(negedge CLK);
    n_cmp++;
    if (PCM_L !== 10'd0) begin n_bad++; $display("FAIL sd_pcm0 got %0d want 0", PCM_L); end
    ones_l = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      ones_l += int'(AUDIO_L) + int'(AUDIO_R);
    end
    n_cmp++;
    if (ones_l !== 0) begin n_bad++; $display("FAIL sd_zero got %0d ones want 0", ones_l); end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_mix();
    test_back_to_back();
    test_fade_release();
    test_reset_mid_fade();
    test_fade_full();
    test_sigma_delta();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
